// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz VGA timing constants and the sync bundle type used by
// the scan generator and every sprite stage downstream of it.
package vga_timing_pkg;

  // Horizontal timing, in pixel clocks
  localparam int H_ACTIVE = 32'd640;
  localparam int H_FP     = 32'd16;
  localparam int H_SYNC   = 32'd96;
  localparam int H_BP     = 32'd48;

  // Vertical timing, in lines
  localparam int V_ACTIVE = 32'd480;
  localparam int V_FP     = 32'd10;
  localparam int V_SYNC   = 32'd2;
  localparam int V_BP     = 32'd33;

  // Derived frame geometry
  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;

  // One sprite coordinate covers a 4x4 pixel block
  localparam int SCALE_SHIFT = 32'd2;

  // Widths of the raster counters and the scaled coordinates
  localparam int CNT_W = 32'd10;
  localparam int X_W   = 32'd8;
  localparam int Y_W   = 32'd7;

  // Sync/blank bundle carried through the delay line
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } sync_bus_t;

  // Idle state of the bundle: syncs inactive (high), picture blanked
  localparam sync_bus_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

endpackage

// File: rtl/sync_delay_line.sv
// WIDTH x DEPTH register shift line with a synchronous active-low reset that
// loads every stage with a caller-supplied value.
module sync_delay_line #(
  parameter int WIDTH = 32'd1,
  parameter int DEPTH = 32'd1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Advance the line one stage per clock; reset fills every stage with rst_val
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= rst_val;
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: free-running pixel/line counters, scaled
// 160x120 sprite coordinates, frame/line ticks, and sync/blank signals
// delayed to line up with the registered sprite colour.
module vga_scan_gen #(
  parameter int PIPE_DELAY = 32'd1,
  parameter int H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP       = vga_timing_pkg::H_FP,
  parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int H_BP       = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP       = vga_timing_pkg::V_FP,
  parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int V_BP       = vga_timing_pkg::V_BP
) (
  input  logic                            VGA_CLK,
  input  logic                            resetn,
  output logic [vga_timing_pkg::X_W-1:0]  xvga,
  output logic [vga_timing_pkg::Y_W-1:0]  yvga,
  output logic                            active,
  output logic                            VGA_HS,
  output logic                            VGA_VS,
  output logic                            VGA_BLANK_N,
  output logic                            frame_tick,
  output logic                            line_tick
);

  localparam int CNT_W = vga_timing_pkg::CNT_W;
  localparam int X_W   = vga_timing_pkg::X_W;
  localparam int Y_W   = vga_timing_pkg::Y_W;
  localparam int SHIFT = vga_timing_pkg::SCALE_SHIFT;

  // Counter compare points, pre-sized to the counter width
  localparam logic [CNT_W-1:0] H_ACT_C   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_B  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_E  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT_C   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_B  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_E  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [CNT_W-1:0]          h_cnt_r;
  logic [CNT_W-1:0]          v_cnt_r;
  logic                      active_s;
  logic [X_W-1:0]            xvga_s;
  logic [Y_W-1:0]            yvga_s;
  logic                      frame_tick_s;
  logic                      line_tick_s;
  vga_timing_pkg::sync_bus_t sync_raw_s;
  vga_timing_pkg::sync_bus_t sync_dly_s;

  // Raster position: h steps every pixel, v steps on each h wrap; both wrap by compare-and-clear
  always_ff @(posedge VGA_CLK) begin
    if (!resetn) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= '0;
      if (v_cnt_r == V_LAST) begin
        v_cnt_r <= '0;
      end else begin
        v_cnt_r <= v_cnt_r + 10'd1;
      end
    end else begin
      h_cnt_r <= h_cnt_r + 10'd1;
      v_cnt_r <= v_cnt_r;
    end
  end

  // Position decodes taken straight from the counter registers, so they add no latency
  always_comb begin
    active_s     = 1'b0;
    xvga_s       = '0;
    yvga_s       = '0;
    sync_raw_s   = vga_timing_pkg::SYNC_IDLE;
    frame_tick_s = 1'b0;
    line_tick_s  = 1'b0;

    if ((h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C)) begin
      active_s = 1'b1;
    end else begin
      active_s = 1'b0;
    end

    // Coordinates are forced to zero in blanking so sprite compares cannot alias there
    if (active_s) begin
      xvga_s = h_cnt_r[SHIFT +: X_W];
      yvga_s = v_cnt_r[SHIFT +: Y_W];
    end else begin
      xvga_s = '0;
      yvga_s = '0;
    end

    if ((h_cnt_r >= H_SYNC_B) && (h_cnt_r < H_SYNC_E)) begin
      sync_raw_s.hs = 1'b0;
    end else begin
      sync_raw_s.hs = 1'b1;
    end

    if ((v_cnt_r >= V_SYNC_B) && (v_cnt_r < V_SYNC_E)) begin
      sync_raw_s.vs = 1'b0;
    end else begin
      sync_raw_s.vs = 1'b1;
    end

    sync_raw_s.blank_n = active_s;

    // Frame tick marks the first pixel of vertical blanking
    if ((h_cnt_r == 10'd0) && (v_cnt_r == V_ACT_C)) begin
      frame_tick_s = 1'b1;
    end else begin
      frame_tick_s = 1'b0;
    end

    if (h_cnt_r == H_LAST) begin
      line_tick_s = 1'b1;
    end else begin
      line_tick_s = 1'b0;
    end
  end

  // Sync and blank wait PIPE_DELAY cycles so they meet the sprite colour at the DAC
  sync_delay_line #(
    .WIDTH (32'd3),
    .DEPTH (PIPE_DELAY)
  ) u_sync_delay (
    .clk     (VGA_CLK),
    .resetn  (resetn),
    .rst_val (vga_timing_pkg::SYNC_IDLE),
    .din     (sync_raw_s),
    .dout    (sync_dly_s)
  );

  assign xvga        = xvga_s;
  assign yvga        = yvga_s;
  assign active      = active_s;
  assign frame_tick  = frame_tick_s;
  assign line_tick   = line_tick_s;
  assign VGA_HS      = sync_dly_s.hs;
  assign VGA_VS      = sync_dly_s.vs;
  assign VGA_BLANK_N = sync_dly_s.blank_n;

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Upstream stage of the sprite display path.
- Generates 640x480@60 Hz VGA timing from the 25 MHz pixel clock.
- Drives the down-scaled 160x120 scan coordinates (xvga, yvga) consumed by every sprite stage.
- Produces HS/VS/BLANK, delayed to line up with the registered sprite colour output, plus a per-frame tick for game logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SCALE_SHIFT, 2, log2 of the pixel-to-coordinate scale (4x4 block per coordinate)
- PIPE_DELAY, 1, cycles of sync/blank delay matching the sprite stage latency (range 1..4)

Ports:
- VGA_CLK  in  1  pixel clock, 25 MHz; all logic on posedge
- resetn  in  1  synchronous, active-low reset
- xvga  out  8  scaled column 0..159; 0 outside the active area
- yvga  out  7  scaled row 0..119; 0 outside the active area
- active  out  1  current counter position is visible (undelayed)
- VGA_HS  out  1  horizontal sync, active low, delayed by PIPE_DELAY
- VGA_VS  out  1  vertical sync, active low, delayed by PIPE_DELAY
- VGA_BLANK_N  out  1  high when visible, delayed by PIPE_DELAY
- frame_tick  out  1  one-cycle pulse at the start of vertical blanking
- line_tick  out  1  one-cycle pulse at the last pixel of every line

Behaviour:
- Clock and reset: one clock, VGA_CLK. resetn is synchronous and active-low. No other clock or async path.
- Counters:
  - h_cnt is 10 bits, range 0..799; increments every cycle and wraps 799->0.
  - v_cnt is 10 bits, range 0..524; increments only on the h wrap; wraps 524->0 on the cycle where h_cnt=799 and v_cnt=524.
- Decodes, combinational from the registered counters, so no added latency:
  - active = (h_cnt<640) & (v_cnt<480)
  - xvga = active ? h_cnt[9:2] : 0
  - yvga = active ? v_cnt[8:2] : 0
- xvga and yvga never exceed 159 and 119, so sprite compares cannot alias in blanking.
- Raw syncs:
  - hs_raw = 0 when 656<=h_cnt<752, else 1
  - vs_raw = 0 when 490<=v_cnt<492, else 1
- Delay line: hs_raw, vs_raw and active pass through a PIPE_DELAY-stage register shift line. For pixel p, VGA_HS, VGA_VS and VGA_BLANK_N appear at cycle p+PIPE_DELAY, aligned with to_display and sprite_color from the sprite stage.
- frame_tick = 1 exactly when h_cnt=0 and v_cnt=480; one pulse per 420000 cycles.
- line_tick = 1 exactly when h_cnt=799, for every line including blanking lines.
- Reset values, applied on the first posedge with resetn=0:
  - h_cnt=0, v_cnt=0
  - all delay stages hold hs=1, vs=1, blank_n=0
  - frame_tick=0, line_tick=0
  - xvga and yvga read 0 from the counter state; active reads 1.
- Reset mid-frame: the next edge with resetn low forces the reset state regardless of position. While resetn stays low, outputs hold the reset values and no tick fires. After release, pixel (0,0) is presented in the first cycle following the deasserting edge. The delay line refills, so VGA_BLANK_N rises PIPE_DELAY cycles later.
- Counter arithmetic: wrap by compare-and-clear only; never rely on natural 10-bit overflow.

Decomposition:
- Shared package/header vga_timing_pkg:
  - the eight timing constants
  - derived H_TOTAL=800, V_TOTAL=525, H_SYNC_START=656, V_SYNC_START=490
  - SCALE_SHIFT
  - coordinate widths X_W=8, Y_W=7
- Sub-module sync_delay_line: parameterised width × depth shift register with a synchronous active-low reset value input. Instantiated once, 3 bits wide, depth PIPE_DELAY.

Test Plan:
- Release reset, run 1 line -> xvga steps 0,0,0,0,1,... and reaches 159 at h_cnt=636..639; xvga=0 for h_cnt 640..799; line_tick high only at h_cnt=799.
- Run 1 frame, PIPE_DELAY=1 -> VGA_HS low for exactly 96 cycles per line, starting at h_cnt=657; VGA_VS low for exactly 1600 cycles (2 lines).
- Full frame count -> frame_tick pulses exactly once per 420000 cycles, at h_cnt=0, v_cnt=480; yvga=119 on lines 476..479 and 0 on lines 480..524.
- Wrap check -> after (h_cnt=799, v_cnt=524), next cycle gives h_cnt=0, v_cnt=0, active=1, xvga=0, yvga=0.
- Assert resetn low for 3 cycles at h_cnt=700, v_cnt=300 -> VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, no ticks; counters restart at (0,0) after release; VGA_BLANK_N=1 one cycle later.
- PIPE_DELAY=3 -> VGA_BLANK_N falls 3 cycles after active falls at h_cnt=640, i.e. at cycle h_cnt=643.
